// File: rtl/vga_regbank_pkg.sv
// vga_regbank_pkg: port numbers, control/status bit positions and default depth
// shared by the VGA register bank and its firmware-facing consumers.
package vga_regbank_pkg;
  localparam int VGA_DEFAULT_DEPTH = 16;
  localparam logic [7:0] VGA_ADDR_PORT = 8'd40;
  localparam logic [7:0] VGA_DATA_PORT = 8'd41;
  localparam logic [7:0] VGA_CTRL_PORT = 8'd42;
  localparam logic [7:0] VGA_STATUS_PORT = 8'd2;
  localparam int CTRL_AUTO_INC = 0;
  localparam int CTRL_DIRECT = 1;
  localparam int CTRL_COMMIT = 7;
  localparam int STAT_VSYNC = 0;
  localparam int STAT_FRAME = 1;
  localparam int STAT_COMMIT = 2;
endpackage

// File: rtl/vga_vsync_edge.sv
// vga_vsync_edge: registers active-low VSync, flags its falling edge combinationally
// and emits a registered one-cycle frame tick.
module vga_vsync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsync,
  output logic o_fall,
  output logic o_tick
);
  logic r_vsync_d;
  logic r_tick;
  assign o_fall = r_vsync_d & ~i_vsync;
  assign o_tick = r_tick;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vsync_d <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_vsync_d <= i_vsync;
      r_tick <= o_fall;
    end
  end
endmodule

// File: rtl/vga_port_regbank.sv
// vga_port_regbank: PicoBlaze port-mapped shadow/active register bank with auto-increment
// pointer, readback, VSync-aligned commit and a sticky frame flag.
module vga_port_regbank
  import vga_regbank_pkg::*;
#(
  parameter int DEPTH = VGA_DEFAULT_DEPTH,
  parameter logic [7:0] ADDR_PORT = VGA_ADDR_PORT,
  parameter logic [7:0] DATA_PORT = VGA_DATA_PORT,
  parameter logic [7:0] CTRL_PORT = VGA_CTRL_PORT,
  parameter logic [7:0] STATUS_PORT = VGA_STATUS_PORT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [7:0]    Port_ID,
  input  logic [7:0]    IN_DATA,
  input  logic          Write_Strobe,
  input  logic          Read_Strobe,
  output logic [7:0]    OUT_DATA,
  input  logic          VSync,
  input  logic [AW-1:0] RdAddr,
  output logic [7:0]    RdData,
  output logic          FrameTick
);
  logic [7:0]    r_shadow [DEPTH];
  logic [7:0]    r_active [DEPTH];
  logic [AW-1:0] r_ptr;
  logic [1:0]    r_ctrl;
  logic          r_frame;
  logic          r_commit;
  logic          w_fall;
  logic          w_commit;
  logic          w_wr_addr;
  logic          w_wr_data;
  logic          w_wr_ctrl;
  logic          w_rd_status;
  logic          w_direct;
  vga_vsync_edge u_edge (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_vsync (VSync),
    .o_fall  (w_fall),
    .o_tick  (FrameTick)
  );
  assign w_wr_addr = Write_Strobe && (Port_ID == ADDR_PORT);
  assign w_wr_data = Write_Strobe && (Port_ID == DATA_PORT);
  assign w_wr_ctrl = Write_Strobe && (Port_ID == CTRL_PORT);
  assign w_rd_status = Read_Strobe && (Port_ID == STATUS_PORT);
  assign w_commit = w_fall && r_commit;
  assign w_direct = w_wr_data && r_ctrl[CTRL_DIRECT];
  assign RdData = r_active[RdAddr];
  assign OUT_DATA = (Port_ID == STATUS_PORT) ? {5'b0, r_commit, r_frame, ~VSync} :
                    (Port_ID == DATA_PORT)   ? r_shadow[r_ptr] :
                    (Port_ID == CTRL_PORT)   ? {6'b0, r_ctrl} : 8'h00;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) r_shadow[i] <= 8'h00;
    end else if (w_wr_data) begin
      r_shadow[r_ptr] <= IN_DATA;
    end
  end
  // a direct write to the entry being committed overrides the copied shadow value
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) r_active[i] <= 8'h00;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_direct && r_ptr == AW'(i)) r_active[i] <= IN_DATA;
        else if (w_commit) r_active[i] <= r_shadow[i];
      end
    end
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ptr <= '0;
      r_ctrl <= 2'b00;
    end else begin
      if (w_wr_addr) r_ptr <= IN_DATA[AW-1:0];
      else if (w_wr_data && r_ctrl[CTRL_AUTO_INC]) r_ptr <= r_ptr + AW'(1);
      if (w_wr_ctrl) r_ctrl <= IN_DATA[1:0];
    end
  end
  // an arm landing on the commit edge survives to the next frame
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_commit <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      if (w_wr_ctrl && IN_DATA[CTRL_COMMIT]) r_commit <= 1'b1;
      else if (w_commit) r_commit <= 1'b0;
      if (w_fall) r_frame <= 1'b1;
      else if (w_rd_status) r_frame <= 1'b0;
    end
  end
endmodule
